// File: rtl/btn_pkg.sv
// Shared definitions for the button front end: channel states, the counter
// width helper and default timing for the 100 MHz board clock.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } chan_state_e;

    // Defaults for a 100 MHz clock: ~96 us debounce, 0.5 s long press, 0.1 s repeat.
    localparam int DEFAULT_NUM_BUTTONS       = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 9600;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;
    localparam int DEFAULT_REPEAT_CYCLES     = 10_000_000;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/hold FSM
// and the hold/repeat counter. Every output comes straight from a flop.
module button_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_i,
    output logic level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o,
    output logic repeat_pulse_o
);

    // The hold counter serves both the long-press and repeat phases.
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int DEB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    // Terminal values are compared one step early so the counters never
    // need to hold the limit itself and can never wrap.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic [1:0]        sync_q;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    chan_state_e       state_q, state_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              sync_bit;
    logic              accept;

    assign sync_bit = sync_q[1];
    // A level change is accepted when the disagreement has lasted the full window.
    assign accept   = (sync_bit != level_q) && (deb_q == DEB_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], button_i};
        end
    end

    // Debounce counter, FSM next state and strobe generation.
    always_comb begin
        deb_d     = deb_q;
        level_d   = level_q;
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        if (sync_bit == level_q) begin
            deb_d = '0;
        end else if (accept) begin
            deb_d   = '0;
            level_d = ~level_q;
        end else begin
            deb_d = deb_q + DEB_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_HELD: begin
                // Release has priority over the long-press strobe.
                if (accept) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (hold_q == LONG_LAST) begin
                    state_d = ST_REPEAT;
                    long_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_REPEAT: begin
                if (accept) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (REPEAT_CYCLES > 0) begin
                    if (hold_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb_q     <= '0;
            hold_q    <= '0;
            state_q   <= ST_IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o         = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;
    assign repeat_pulse_o  = repeat_q;

endmodule

// File: rtl/button_events.sv
// Multi-channel button front end: one independent button_channel per input.
module button_events
    import btn_pkg::*;
#(
    parameter int NUM_BUTTONS       = DEFAULT_NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_pulse,
    output logic [NUM_BUTTONS-1:0] repeat_pulse
);

    // Channels share nothing but clock and reset.
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES)
        ) u_chan (
            .clock          (clock),
            .reset          (reset),
            .button_i       (buttons[gi]),
            .level_o        (level[gi]),
            .press_pulse_o  (press_pulse[gi]),
            .release_pulse_o(release_pulse[gi]),
            .long_pulse_o   (long_pulse[gi]),
            .repeat_pulse_o (repeat_pulse[gi])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with DEBOUNCE=4, LONG=10, REPEAT=3 (and a
// second copy with REPEAT=0). Log index j holds the outputs seen after edge E+j,
// where E is the first edge sampling the new button pattern.
module tb_button_events;

    localparam int NB = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] buttons = '0;
    logic [NB-1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic [NB-1:0] level2, press2, release2, long2, repeat2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [NB-1:0] pr_log [0:63];
    logic [NB-1:0] rl_log [0:63];
    logic [NB-1:0] lg_log [0:63];
    logic [NB-1:0] rp_log [0:63];
    logic [NB-1:0] lv_log [0:63];
    logic [NB-1:0] lg2_log[0:63];
    logic [NB-1:0] rp2_log[0:63];

    always #5 clock = ~clock;

    button_events #(
        .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .REPEAT_CYCLES(3)
    ) dut (
        .clock(clock), .reset(reset), .buttons(buttons), .level(level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    button_events #(
        .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .REPEAT_CYCLES(0)
    ) dut_norep (
        .clock(clock), .reset(reset), .buttons(buttons), .level(level2),
        .press_pulse(press2), .release_pulse(release2),
        .long_pulse(long2), .repeat_pulse(repeat2)
    );

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drive pattern for high_cycles edges, then low, logging total cycles.
    task automatic run(input logic [NB-1:0] mask, input int high_cycles, input int total);
        for (int j = 0; j < total; j++) begin
            buttons = (j < high_cycles) ? mask : '0;
            tick();
            pr_log[j]  = press_pulse;
            rl_log[j]  = release_pulse;
            lg_log[j]  = long_pulse;
            rp_log[j]  = repeat_pulse;
            lv_log[j]  = level;
            lg2_log[j] = long2;
            rp2_log[j] = repeat2;
        end
        $display("run mask=%b high=%0d cycles=%0d done", mask, high_cycles, total);
    endtask

    function automatic logic log_bit(input int kind, input int j, input int ch);
        case (kind)
            0:       return pr_log[j][ch];
            1:       return rl_log[j][ch];
            2:       return lg_log[j][ch];
            3:       return rp_log[j][ch];
            4:       return lv_log[j][ch];
            5:       return lg2_log[j][ch];
            default: return rp2_log[j][ch];
        endcase
    endfunction

    function automatic int first_hit(input int kind, input int ch, input int total);
        for (int j = 0; j < total; j++) begin
            if (log_bit(kind, j, ch)) return j;
        end
        return -1;
    endfunction

    function automatic int count_hits(input int kind, input int ch, input int total);
        int n = 0;
        for (int j = 0; j < total; j++) begin
            if (log_bit(kind, j, ch)) n++;
        end
        return n;
    endfunction

    function automatic int multi_strobe(input int ch, input int total);
        int n = 0;
        for (int j = 0; j < total; j++) begin
            if ((int'(pr_log[j][ch]) + int'(rl_log[j][ch]) + int'(lg_log[j][ch]) + int'(rp_log[j][ch])) > 1) n++;
        end
        return n;
    endfunction

    initial begin
        // Reset state
        reset = 1'b1;
        buttons = '0;
        repeat (3) tick();
        check("rst_level",   int'(level), 0);
        check("rst_press",   int'(press_pulse), 0);
        check("rst_release", int'(release_pulse), 0);
        check("rst_long",    int'(long_pulse), 0);
        check("rst_repeat",  int'(repeat_pulse), 0);
        reset = 1'b0;
        repeat (2) tick();

        // Clean long hold on ch0: 30 high cycles
        run(2'b01, 30, 45);
        check("hold_level_pre",  int'(lv_log[4][0]), 0);
        check("hold_level_post", int'(lv_log[5][0]), 1);
        check("hold_press_at",   first_hit(0, 0, 45), 5);
        check("hold_press_n",    count_hits(0, 0, 45), 1);
        check("hold_long_at",    first_hit(2, 0, 45), 15);
        check("hold_long_n",     count_hits(2, 0, 45), 1);
        check("hold_rep_at",     first_hit(3, 0, 45), 18);
        check("hold_rep21",      int'(rp_log[21][0]), 1);
        check("hold_rep24",      int'(rp_log[24][0]), 1);
        check("hold_rep_n",      count_hits(3, 0, 45), 6);
        check("hold_rel_at",     first_hit(1, 0, 45), 35);
        check("hold_rel_n",      count_hits(1, 0, 45), 1);
        check("hold_multi",      multi_strobe(0, 45), 0);
        check("hold_ch1_quiet",  count_hits(4, 1, 45), 0);

        // Glitch on ch1: 3 high cycles is rejected, 4 is accepted
        run(2'b10, 3, 12);
        check("glitch_level", count_hits(4, 1, 12), 0);
        check("glitch_press", count_hits(0, 1, 12), 0);
        run(2'b10, 4, 15);
        check("min_press_at", first_hit(0, 1, 15), 5);
        check("min_rel_at",   first_hit(1, 1, 15), 9);

        // Short press on ch0: 8 high cycles
        run(2'b01, 8, 20);
        check("short_press_at", first_hit(0, 0, 20), 5);
        check("short_rel_at",   first_hit(1, 0, 20), 13);
        check("short_long_n",   count_hits(2, 0, 20), 0);

        // Repeat-disabled build, 40 high cycles
        run(2'b01, 40, 50);
        check("norep_long_at", first_hit(5, 0, 50), 15);
        check("norep_long_n",  count_hits(5, 0, 50), 1);
        check("norep_rep_n",   count_hits(6, 0, 50), 0);

        // Reset while ch0 is in REPEAT with the button still held
        buttons = 2'b01;
        repeat (21) tick();
        check("pre_rst_level", int'(level[0]), 1);
        reset = 1'b1;
        tick();
        check("mid_rst_level",   int'(level), 0);
        check("mid_rst_release", int'(release_pulse), 0);
        check("mid_rst_strobes", int'(press_pulse | long_pulse | repeat_pulse), 0);
        reset = 1'b0;
        run(2'b01, 20, 30);
        check("post_rst_press_at", first_hit(0, 0, 30), 5);
        check("post_rst_rel_at",   first_hit(1, 0, 30), 25);

        // Simultaneous press on both channels, 20 high cycles
        run(2'b11, 20, 32);
        check("sim_press0", first_hit(0, 0, 32), 5);
        check("sim_press1", first_hit(0, 1, 32), 5);
        check("sim_long0",  first_hit(2, 0, 32), 15);
        check("sim_long1",  first_hit(2, 1, 32), 15);
        check("sim_rep0_n", count_hits(3, 0, 32), 3);
        check("sim_rep1_n", count_hits(3, 1, 32), 3);
        check("sim_rel0",   first_hit(1, 0, 32), 25);
        check("sim_rel1",   first_hit(1, 1, 32), 25);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
